pipeline_decode: RTL
====================

# pipeline_decode

Decode stage of the 5-stage RV32I pipeline, directly downstream of `pipeline_fetch`. It latches fetch outputs into an IF/ID register and decodes the instruction. It owns the 32×32 register file, with a write port driven from WB, and generates immediates. It detects load-use hazards, stalling fetch and inserting bubbles, and presents a registered ID/EX bundle to the execute stage.

## Interface
- No parameters. XLEN is fixed at 32.
- `clk_i`  in  1  clock
- `reset_i`  in  1  reset; synchronous, active-high
- `instruction_i`  in  32  fetched instruction (fetch `instruction_o`)
- `pc_i`  in  32  PC of `instruction_i` (fetch `pc_o`)
- `pcsrc_i`  in  32  PC+4 of `instruction_i` (fetch `pcsrc_o`)
- `flush_i`  in  1  branch/jump taken in EX (same net as fetch `pc_select_i`)
- `wb_en_i`  in  1  register-file write enable from WB
- `wb_rd_i`  in  5  WB destination register
- `wb_data_i`  in  32  WB write data
- `stall_o`  out  1  load-use stall; fetch holds `pc_reg` and `instruction_o` while high
- `valid_o`  out  1  ID/EX slot holds a real instruction
- `pc_o`, `pcsrc_o`  out  32 each  PC and PC+4 of the instruction in ID/EX
- `rs1_data_o`, `rs2_data_o`  out  32 each  register operands
- `imm_o`  out  32  sign-extended immediate
- `rs1_o`, `rs2_o`, `rd_o`  out  5 each  register indices
- `opcode_o`  out  7; `funct3_o`  out  3; `funct7b5_o`  out  1 (instr[30])
- `illegal_o`  out  1  opcode not in the RV32I base set

## Operation
- **IF/ID register:** captures `instruction_i`, `pc_i`, `pcsrc_i` each cycle and sets `ifid_valid`=1.
- **Decode fields:** opcode=[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20].
- **Immediate by opcode:**
  - I: 0010011, 0000011, 1100111
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
  - R (0110011) and all others: imm=0
- **Legal opcodes** are the set above plus 0110011 and 1110011; any other opcode gives `illegal_o`=1.
- **Register file:**
  - Two combinational read ports, one write port, written on the clock edge.
  - x0 always reads 0. Writes with `wb_rd_i`=0 are discarded.
  - Write-first bypass: if `wb_en_i` is high, `wb_rd_i`≠0, and `wb_rd_i` equals the read index, the read returns `wb_data_i` in the same cycle.
- **Load-use hazard:**
  - Condition: the ID/EX slot is valid, its opcode is 0000011, its rd≠0, and that rd equals a used source of the IF/ID instruction.
  - rs1 is used by all opcodes except 0110111, 0010111 and 1101111.
  - rs2 is used by 0110011, 0100011 and 1100011.
  - Response: `stall_o`=1 combinationally. IF/ID holds its contents, and ID/EX loads a bubble (`valid_o`=0, all other fields 0).
- **Flush:** `flush_i`=1 clears `ifid_valid` and `valid_o` on the next edge. Flush has priority over stall, and `stall_o` is forced to 0 while `flush_i` is high.
- **Bubble forwarding:** an invalid IF/ID slot propagates as a bubble, and `stall_o` is never asserted for it.

## Timing
- **Latency:** inputs sampled at edge k appear on the ID/EX outputs after edge k+1, i.e. 2 edges.
- **`stall_o`:** combinational from IF/ID and ID/EX state. A single load-use hazard stalls for exactly 1 cycle, because the load leaves ID/EX on the bubble edge.
- **Reset:**
  - Every output is 0 and both valid bits are 0.
  - All 32 registers clear to 0.
  - Reset overrides flush, stall and writeback.
  - A reset asserted mid-stall takes effect on the next edge.
- **Simultaneous writeback and stall:** the write commits normally, and the held IF/ID instruction re-reads the new value on the following cycle.

## Structure
- **Package `pipeline_pkg`:**
  - Opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_SYSTEM).
  - Immediate-type enum (IMM_I/S/B/U/J/NONE).
  - Shared by the fetch, execute and hazard logic.
- **Sub-module `pipeline_regfile`:** 32×32 array with synchronous reset, two read ports with write-first bypass, and one write port.
- **Top level:** IF/ID register, immediate generator, hazard logic and ID/EX register.

## Test plan
- **Reset:** assert reset 2 cycles, then release with `instruction_i`=0x00500093 (addi x1,x0,5) and `pc_i`=0.
  - Expect all outputs 0 during reset.
  - 2 edges after release: `valid_o`=1, `rd_o`=1, `rs1_o`=0, `imm_o`=5, `rs1_data_o`=0.
- **Load-use:** 0x0000A103 (lw x2,0(x1)) then 0x002101B3 (add x3,x2,x2).
  - Expect `stall_o`=1 for exactly 1 cycle and one ID/EX bubble (`valid_o`=0).
  - The add then appears with `rs1_o`=`rs2_o`=2.
- **Bypass:** `wb_en_i`=1, `wb_rd_i`=5, `wb_data_i`=0xDEADBEEF, in the same cycle that IF/ID holds 0x00028333 (add x6,x5,x0).
  - Expect `rs1_data_o`=0xDEADBEEF.
  - A write to rd=0 with 0x1234 leaves x0 reading 0.
- **Branch immediate:** 0x00208463 (beq x1,x2,+8).
  - Expect `imm_o`=8, `funct3_o`=0, `rs2_o`=2.
  - A jal with offset −4 (0xFFDFF06F) gives `imm_o`=0xFFFFFFFC.
- **Flush over stall:** create the load-use pair, then assert `flush_i` in the stall cycle.
  - Expect `stall_o`=0, and `valid_o`=0 for the next two ID/EX slots.
- **Illegal opcode:** `instruction_i`=0x0000007F.
  - Expect `illegal_o`=1, `valid_o`=1, `imm_o`=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - RV32I opcode constants, immediate types and decode helpers
package pipeline_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  function automatic imm_type_e imm_type(input logic [6:0] op);
    case (op)
      OP_IMM, OP_LOAD, OP_JALR: imm_type = IMM_I;
      OP_STORE:                 imm_type = IMM_S;
      OP_BRANCH:                imm_type = IMM_B;
      OP_LUI, OP_AUIPC:         imm_type = IMM_U;
      OP_JAL:                   imm_type = IMM_J;
      default:                  imm_type = IMM_NONE;
    endcase
  endfunction

  function automatic logic [31:0] gen_imm(input logic [31:0] instr);
    case (imm_type(instr[6:0]))
      IMM_I:   gen_imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   gen_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   gen_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   gen_imm = {instr[31:12], 12'b0};
      IMM_J:   gen_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: gen_imm = '0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    is_legal = (imm_type(op) != IMM_NONE) || (op == OP_REG) || (op == OP_SYSTEM);
  endfunction

  // U-type and JAL carry no rs1 field; only R, S and B read rs2.
  function automatic logic uses_rs1(input logic [6:0] op);
    uses_rs1 = !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    uses_rs2 = (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/pipeline_regfile.sv
// rtl/pipeline_regfile.sv - 32x32 register file, two write-first read ports, one write port
module pipeline_regfile
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  input  logic        wen,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wen && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // A nonzero read index matching the write index implies waddr is nonzero too.
  assign rdata_a = (raddr_a == '0) ? '0 :
                   (wen && (waddr == raddr_a)) ? wdata : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 :
                   (wen && (waddr == raddr_b)) ? wdata : regs[raddr_b];

endmodule

// File: rtl/pipeline_decode.sv
// rtl/pipeline_decode.sv - RV32I decode stage: IF/ID latch, register file, load-use hazard, ID/EX latch
module pipeline_decode
  import pipeline_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] instruction_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pcsrc_i,
  input  logic        flush_i,
  input  logic        wb_en_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pcsrc_o,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  output logic [31:0] imm_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [6:0]  opcode_o,
  output logic [2:0]  funct3_o,
  output logic        funct7b5_o,
  output logic        illegal_o
);

  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pcsrc;

  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        hazard;
  logic        bubble;

  assign opcode = ifid_instr[6:0];
  assign rd     = ifid_instr[11:7];
  assign rs1    = ifid_instr[19:15];
  assign rs2    = ifid_instr[24:20];

  pipeline_regfile u_regfile (
    .clk     (clk_i),
    .reset   (reset_i),
    .raddr_a (rs1),
    .raddr_b (rs2),
    .rdata_a (rs1_data),
    .rdata_b (rs2_data),
    .wen     (wb_en_i),
    .waddr   (wb_rd_i),
    .wdata   (wb_data_i)
  );

  // The load sitting in ID/EX produces its data too late for the instruction behind it.
  assign hazard = valid_o && (opcode_o == OP_LOAD) && (rd_o != '0) &&
                  ((uses_rs1(opcode) && (rs1 == rd_o)) ||
                   (uses_rs2(opcode) && (rs2 == rd_o)));
  assign stall_o = ifid_valid && !flush_i && hazard;
  assign bubble  = flush_i || stall_o || !ifid_valid;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
      ifid_pcsrc <= '0;
    end else if (flush_i) begin
      ifid_valid <= 1'b0;
    end else if (!stall_o) begin
      ifid_valid <= 1'b1;
      ifid_instr <= instruction_i;
      ifid_pc    <= pc_i;
      ifid_pcsrc <= pcsrc_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || bubble) begin
      valid_o    <= 1'b0;
      pc_o       <= '0;
      pcsrc_o    <= '0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      imm_o      <= '0;
      rs1_o      <= '0;
      rs2_o      <= '0;
      rd_o       <= '0;
      opcode_o   <= '0;
      funct3_o   <= '0;
      funct7b5_o <= 1'b0;
      illegal_o  <= 1'b0;
    end else begin
      valid_o    <= 1'b1;
      pc_o       <= ifid_pc;
      pcsrc_o    <= ifid_pcsrc;
      rs1_data_o <= rs1_data;
      rs2_data_o <= rs2_data;
      imm_o      <= gen_imm(ifid_instr);
      rs1_o      <= rs1;
      rs2_o      <= rs2;
      rd_o       <= rd;
      opcode_o   <= opcode;
      funct3_o   <= ifid_instr[14:12];
      funct7b5_o <= ifid_instr[30];
      illegal_o  <= !is_legal(opcode);
    end
  end

endmodule
